gshare_bp: RTL and testbench

Parametrised gshare branch predictor sitting between the decoder, instruction fetch and the reorder buffer. On each decoded branch it combinationally predicts direction from a table of saturating counters, indexed by PC XOR global history, and supplies the next fetch PC. It keeps a speculative global history register (GHR) and repairs it from the ROB on a mispredict. Lookup and mispredict counts are exposed for performance measurement.

---
 rtl/gshare_bp_if.sv | 40 ++++
 rtl/gshare_bp.sv | 128 ++++++++++++
 tb/tb_gshare_bp.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/gshare_bp_if.sv
// Decoder/ROB-facing bus of the gshare branch predictor.
// The master side is the pipeline (decoder + ROB). The slave side is the predictor.
`ifndef AddressWidth
`define AddressWidth 32
`endif

interface gshare_bp_if #(
  parameter int HIST_W = 6,
  parameter int CNT_W  = 32
) ();
  // decoder lookup
  logic                     decoder_bp_en_in;
  logic [`AddressWidth-1:0] decoder_bp_pc_in;
  logic [`AddressWidth-1:0] decoder_bp_target_in;
  // prediction
  logic                     bp_taken_out;
  logic [`AddressWidth-1:0] bp_if_pc_out;
  logic [HIST_W-1:0]        bp_hist_out;
  // ROB resolve
  logic                     rob_bp_en_in;
  logic                     rob_bp_correct_in;
  logic                     rob_bp_taken_in;
  logic [`AddressWidth-1:0] rob_bp_pc_in;
  logic [HIST_W-1:0]        rob_bp_hist_in;
  // performance counters
  logic [CNT_W-1:0]         bp_lookup_cnt_out;
  logic [CNT_W-1:0]         bp_miss_cnt_out;

  modport master (
    output decoder_bp_en_in, decoder_bp_pc_in, decoder_bp_target_in,
    output rob_bp_en_in, rob_bp_correct_in, rob_bp_taken_in, rob_bp_pc_in, rob_bp_hist_in,
    input  bp_taken_out, bp_if_pc_out, bp_hist_out, bp_lookup_cnt_out, bp_miss_cnt_out
  );

  modport slave (
    input  decoder_bp_en_in, decoder_bp_pc_in, decoder_bp_target_in,
    input  rob_bp_en_in, rob_bp_correct_in, rob_bp_taken_in, rob_bp_pc_in, rob_bp_hist_in,
    output bp_taken_out, bp_if_pc_out, bp_hist_out, bp_lookup_cnt_out, bp_miss_cnt_out
  );
endinterface

// File: rtl/gshare_bp.sv
// gshare branch predictor: a table of saturating counters indexed by
// (pc>>2) XOR global history, with a speculative GHR that the ROB repairs
// on a mispredict. Prediction is combinational from current state.
`ifndef AddressWidth
`define AddressWidth 32
`endif

module gshare_bp #(
  parameter int IDX_W  = 7,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 6,
  parameter int CNT_W  = 32
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  logic      rdy_in,
  gshare_bp_if.slave bus
);

  localparam int ADDR_W = `AddressWidth;
  localparam int DEPTH  = 1 << IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  // weakly not-taken: 0 followed by all ones
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

  // Table index: word address folded with zero-extended history.
  function automatic logic [IDX_W-1:0] tbl_idx(input logic [ADDR_W-1:0] pc,
                                                input logic [HIST_W-1:0] h);
    return IDX_W'((pc >> 2) ^ ADDR_W'(h));
  endfunction

  // Shift a new outcome into the history; the oldest bit falls off the top.
  function automatic logic [HIST_W-1:0] hist_push(input logic [HIST_W-1:0] h,
                                                  input logic              b);
    return HIST_W'({h, b});
  endfunction

  // Saturating counter step; clamps at both ends.
  function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] ctr,
                                                input logic             up);
    logic [CTR_W-1:0] res;
    if (up) begin
      res = (ctr == CTR_MAX) ? ctr : ctr + CTR_ONE;
    end else begin
      res = (ctr == CTR_ZERO) ? ctr : ctr - CTR_ONE;
    end
    return res;
  endfunction

  logic [CTR_W-1:0]  table_q [DEPTH];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0]  lookup_cnt_q, lookup_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  lk_idx_s;
  logic [CTR_W-1:0]  lk_ctr_s;
  logic              lk_taken_s;
  logic [IDX_W-1:0]  rs_idx_s;
  logic [CTR_W-1:0]  rs_ctr_d;
  logic              mispredict_s;

  assign lk_idx_s     = tbl_idx(bus.decoder_bp_pc_in, ghr_q);
  assign lk_ctr_s     = table_q[lk_idx_s];
  assign lk_taken_s   = bus.decoder_bp_en_in & lk_ctr_s[CTR_W-1];
  assign rs_idx_s     = tbl_idx(bus.rob_bp_pc_in, bus.rob_bp_hist_in);
  assign rs_ctr_d     = sat_step(table_q[rs_idx_s], bus.rob_bp_taken_in);
  assign mispredict_s = bus.rob_bp_en_in & ~bus.rob_bp_correct_in;

  assign bus.bp_taken_out      = lk_taken_s;
  assign bus.bp_if_pc_out      = lk_taken_s ? bus.decoder_bp_target_in
                                            : bus.decoder_bp_pc_in + ADDR_W'(4);
  assign bus.bp_hist_out       = ghr_q;
  assign bus.bp_lookup_cnt_out = lookup_cnt_q;
  assign bus.bp_miss_cnt_out   = miss_cnt_q;

  // Next GHR and counters; a mispredict repair beats the wrong-path speculative shift.
  always_comb begin
    ghr_d        = ghr_q;
    lookup_cnt_d = lookup_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (rdy_in) begin
      if (mispredict_s) begin
        ghr_d = hist_push(bus.rob_bp_hist_in, bus.rob_bp_taken_in);
      end else if (bus.decoder_bp_en_in) begin
        ghr_d = hist_push(ghr_q, lk_taken_s);
      end else begin
        ghr_d = ghr_q;
      end
      if (bus.decoder_bp_en_in) begin
        lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
      end else begin
        lookup_cnt_d = lookup_cnt_q;
      end
      if (mispredict_s) begin
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end else begin
        miss_cnt_d = miss_cnt_q;
      end
    end else begin
      ghr_d        = ghr_q;
      lookup_cnt_d = lookup_cnt_q;
      miss_cnt_d   = miss_cnt_q;
    end
  end

  // State update: async clear of table/history/counters, everything frozen while not ready.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= CTR_INIT;
      end
      ghr_q        <= {HIST_W{1'b0}};
      lookup_cnt_q <= {CNT_W{1'b0}};
      miss_cnt_q   <= {CNT_W{1'b0}};
    end else if (rdy_in) begin
      ghr_q        <= ghr_d;
      lookup_cnt_q <= lookup_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      if (bus.rob_bp_en_in) begin
        table_q[rs_idx_s] <= rs_ctr_d;
      end
    end
  end

endmodule

// File: tb/tb_gshare_bp.sv
// Directed + randomized bench for gshare_bp against an integer reference model.
`ifndef AddressWidth
`define AddressWidth 32
`endif

module tb_gshare_bp;
  localparam int IDX_W  = 7;
  localparam int CTR_W  = 2;
  localparam int HIST_W = 6;
  localparam int CNT_W  = 32;
  localparam int AW     = `AddressWidth;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int CMAX   = (1 << CTR_W) - 1;
  localparam int HMASK  = (1 << HIST_W) - 1;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic rdy_in;

  always #5 clk_in = ~clk_in;

  gshare_bp_if #(.HIST_W(HIST_W), .CNT_W(CNT_W)) bus ();

  gshare_bp #(.IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .CNT_W(CNT_W)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .rdy_in  (rdy_in),
    .bus     (bus)
  );

  // reference model state
  int          m_tbl [DEPTH];
  int          m_ghr;
  logic [31:0] m_lk;
  logic [31:0] m_ms;

  int vectors = 0;
  int miscompares = 0;

  function automatic int midx(input logic [31:0] pc, input int h);
    return ((pc >> 2) ^ h) % DEPTH;
  endfunction

  // PC that makes the next lookup hit the given entry under the current model history
  function automatic logic [31:0] pc_for(input int entry);
    return 32'(((entry ^ m_ghr) % DEPTH) * 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = (1 << (CTR_W - 1)) - 1;
    m_ghr = 0;
    m_lk  = 32'd0;
    m_ms  = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_state();
    chk("taken_idle", 64'(bus.bp_taken_out), 64'(0));
    chk("hist", 64'(bus.bp_hist_out), 64'(m_ghr));
    chk("lookup_cnt", 64'(bus.bp_lookup_cnt_out), 64'(m_lk));
    chk("miss_cnt", 64'(bus.bp_miss_cnt_out), 64'(m_ms));
  endtask

  // One clock cycle: drive, check predictions against the model, advance the model.
  task automatic cycle(input bit rdy, input bit den, input logic [31:0] dpc,
                       input logic [31:0] dtgt, input bit ren, input bit rcorr,
                       input bit rtk, input logic [31:0] rpc, input int rhist);
    int  c;
    int  ri;
    bit  tk;
    @(negedge clk_in);
    rdy_in                   = rdy;
    bus.decoder_bp_en_in     = den;
    bus.decoder_bp_pc_in     = dpc;
    bus.decoder_bp_target_in = dtgt;
    bus.rob_bp_en_in         = ren;
    bus.rob_bp_correct_in    = rcorr;
    bus.rob_bp_taken_in      = rtk;
    bus.rob_bp_pc_in         = rpc;
    bus.rob_bp_hist_in       = HIST_W'(rhist);
    #1;
    c  = m_tbl[midx(dpc, m_ghr)];
    tk = den && (c >= (1 << (CTR_W - 1)));
    chk("taken", 64'(bus.bp_taken_out), 64'(tk));
    if (den) chk("if_pc", 64'(bus.bp_if_pc_out), 64'(tk ? dtgt : dpc + 32'd4));
    chk("hist", 64'(bus.bp_hist_out), 64'(m_ghr));
    chk("lookup_cnt", 64'(bus.bp_lookup_cnt_out), 64'(m_lk));
    chk("miss_cnt", 64'(bus.bp_miss_cnt_out), 64'(m_ms));
    if (rdy) begin
      if (ren) begin
        ri = midx(rpc, rhist & HMASK);
        if (rtk) m_tbl[ri] = (m_tbl[ri] < CMAX) ? m_tbl[ri] + 1 : CMAX;
        else     m_tbl[ri] = (m_tbl[ri] > 0) ? m_tbl[ri] - 1 : 0;
      end
      if (ren && !rcorr) begin
        m_ghr = (((rhist & HMASK) << 1) | int'(rtk)) & HMASK;
        m_ms  = m_ms + 32'd1;
      end else if (den) begin
        m_ghr = ((m_ghr << 1) | int'(tk)) & HMASK;
      end
      if (den) m_lk = m_lk + 32'd1;
    end
  endtask

  initial begin
    int e;
    // reset
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    bus.decoder_bp_en_in = 1'b0; bus.decoder_bp_pc_in = '0; bus.decoder_bp_target_in = '0;
    bus.rob_bp_en_in = 1'b0; bus.rob_bp_correct_in = 1'b0; bus.rob_bp_taken_in = 1'b0;
    bus.rob_bp_pc_in = '0; bus.rob_bp_hist_in = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_idle_state();
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // first lookup from reset: not taken, fall-through pc
    cycle(1, 1, 32'h100, 32'h200, 0, 0, 0, 32'h0, 0);
    chk("first_if_pc", 64'(bus.bp_if_pc_out), 64'(32'h104));
    // two taken mispredicts on entry 0x40, then lookup with ghr=1 hits 0x41
    cycle(1, 0, 32'h0, 32'h0, 1, 0, 1, 32'h100, 0);
    cycle(1, 0, 32'h0, 32'h0, 1, 0, 1, 32'h100, 0);
    cycle(1, 1, 32'h100, 32'h300, 0, 0, 0, 32'h0, 0);
    // entry 0x40 should now predict taken
    e = 'h40;
    cycle(1, 1, pc_for(e), 32'h400, 0, 0, 0, 32'h0, 0);

    // saturation high: 5 taken, one not-taken leaves it still taken
    e = 'h15;
    for (int i = 0; i < 5; i++) cycle(1, 0, 32'h0, 32'h0, 1, 1, 1, 32'(e * 4), 0);
    cycle(1, 0, 32'h0, 32'h0, 1, 1, 0, 32'(e * 4), 0);
    cycle(1, 1, pc_for(e), 32'h500, 0, 0, 0, 32'h0, 0);
    // saturation low: 5 not-taken, one taken leaves it not taken
    for (int i = 0; i < 5; i++) cycle(1, 0, 32'h0, 32'h0, 1, 1, 0, 32'(e * 4), 0);
    cycle(1, 0, 32'h0, 32'h0, 1, 1, 1, 32'(e * 4), 0);
    cycle(1, 1, pc_for(e), 32'h600, 0, 0, 0, 32'h0, 0);

    // history shift: force 0x40/0x41 strong taken, repair ghr to 0, two lookups
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 32'h0, 32'h0, 1, 1, 1, 32'h100, 0);
      cycle(1, 0, 32'h0, 32'h0, 1, 1, 1, 32'h104, 0);
    end
    cycle(1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h400, 0);
    cycle(1, 1, 32'h100, 32'h700, 0, 0, 0, 32'h0, 0);
    cycle(1, 1, 32'h104, 32'h800, 0, 0, 0, 32'h0, 0);
    cycle(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0);
    chk("ghr_after_shift", 64'(bus.bp_hist_out), 64'(3));

    // same-cycle lookup + repair: repair wins, lookup sees old counter
    cycle(1, 1, 32'h100, 32'h900, 1, 0, 0, 32'h100, 'h2A);
    cycle(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0);
    chk("ghr_repair", 64'(bus.bp_hist_out), 64'(6'h14));

    // rdy low with both enables: nothing moves
    cycle(0, 1, 32'h100, 32'hA00, 1, 0, 1, 32'h100, 'h11);
    cycle(0, 1, 32'h104, 32'hA00, 1, 0, 0, 32'h104, 'h05);
    cycle(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
            {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC,
            $urandom_range(0, 1), ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
            32'($urandom_range(0, 63) * 4), int'($urandom_range(0, HMASK)));
    end

    // async reset mid-cycle with rdy high, no clock edge needed
    @(negedge clk_in);
    rdy_in = 1'b1;
    bus.decoder_bp_en_in = 1'b0;
    bus.rob_bp_en_in = 1'b1;
    #2;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    check_idle_state();
    @(negedge clk_in);
    bus.rob_bp_en_in = 1'b0;
    rst_n_in = 1'b1;
    for (int n = 0; n < 40; n++) begin
      cycle(1'b1, $urandom_range(0, 1), {$urandom} & 32'h0000_03FC, 32'h1234,
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            32'($urandom_range(0, 31) * 4), int'($urandom_range(0, HMASK)));
    end
    cycle(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
